// File: rtl/lq_multiport_if.sv
// Port bundle between the LSU backend and lq_multiport.
// master drives requests into the queue; slave is the queue side.
interface lq_multiport_if #(
    parameter int DEPTH     = 32,
    parameter int DIS_PORTS = 2,
    parameter int LD_PIPES  = 2,
    parameter int ST_PIPES  = 2,
    parameter int WB_PORTS  = 2,
    parameter int RF_PORTS  = 2,
    parameter int ROB_W     = 7,
    parameter int PREG_W    = 7,
    parameter int DATA_W    = 64,
    parameter int PADDR_W   = 32
);
    localparam int QW    = $clog2(DEPTH);
    localparam int BYTES = DATA_W / 8;
    localparam int CW    = $clog2(DIS_PORTS) + 1;

    logic [DIS_PORTS-1:0]          dis_valid;
    logic [DIS_PORTS*ROB_W-1:0]    dis_rob;
    logic [DIS_PORTS*PREG_W-1:0]   dis_rd;
    logic                          dis_ready;
    logic [QW:0]                   lq_tail;

    logic [LD_PIPES-1:0]           ld_en;
    logic [LD_PIPES*QW-1:0]        ld_idx;
    logic [LD_PIPES-1:0]           ld_miss;
    logic [LD_PIPES*PADDR_W-1:0]   ld_paddr;
    logic [LD_PIPES*BYTES-1:0]     ld_mask;
    logic [LD_PIPES*BYTES-1:0]     ld_fwd_mask;
    logic [LD_PIPES*DATA_W-1:0]    ld_data;

    logic [RF_PORTS-1:0]           rf_en;
    logic [RF_PORTS*QW-1:0]        rf_idx;
    logic [RF_PORTS*DATA_W-1:0]    rf_data;

    logic [WB_PORTS-1:0]           wb_valid;
    logic [WB_PORTS-1:0]           wb_ready;
    logic [WB_PORTS*ROB_W-1:0]     wb_rob;
    logic [WB_PORTS*PREG_W-1:0]    wb_rd;
    logic [WB_PORTS*DATA_W-1:0]    wb_data;

    logic [CW-1:0]                 commit_num;
    logic                          redirect;
    logic [ROB_W-1:0]              redirect_rob;

    logic [ST_PIPES-1:0]           st_en;
    logic [ST_PIPES*PADDR_W-1:0]   st_paddr;
    logic [ST_PIPES*BYTES-1:0]     st_mask;
    logic [ST_PIPES*(QW+1)-1:0]    st_lq;

    logic                          vio_valid;
    logic [ROB_W-1:0]              vio_rob;
    logic [QW:0]                   count;

    modport master (
        output dis_valid, dis_rob, dis_rd,
        output ld_en, ld_idx, ld_miss, ld_paddr, ld_mask, ld_fwd_mask, ld_data,
        output rf_en, rf_idx, rf_data, wb_ready, commit_num, redirect, redirect_rob,
        output st_en, st_paddr, st_mask, st_lq,
        input  dis_ready, lq_tail, wb_valid, wb_rob, wb_rd, wb_data, vio_valid, vio_rob, count
    );

    modport slave (
        input  dis_valid, dis_rob, dis_rd,
        input  ld_en, ld_idx, ld_miss, ld_paddr, ld_mask, ld_fwd_mask, ld_data,
        input  rf_en, rf_idx, rf_data, wb_ready, commit_num, redirect, redirect_rob,
        input  st_en, st_paddr, st_mask, st_lq,
        output dis_ready, lq_tail, wb_valid, wb_rob, wb_rd, wb_data, vio_valid, vio_rob, count
    );
endinterface

// File: rtl/lq_multiport.sv
// Multiport load queue: circular buffer of in-flight loads with miss refill merge,
// oldest-first miss writeback, redirect squash and store-to-load violation detection.
module lq_multiport #(
    parameter int DEPTH     = 32,
    parameter int DIS_PORTS = 2,
    parameter int LD_PIPES  = 2,
    parameter int ST_PIPES  = 2,
    parameter int WB_PORTS  = 2,
    parameter int RF_PORTS  = 2,
    parameter int ROB_W     = 7,
    parameter int PREG_W    = 7,
    parameter int DATA_W    = 64,
    parameter int PADDR_W   = 32
) (
    input logic           clk,
    input logic           rst,
    lq_multiport_if.slave bus
);
    localparam int QW    = $clog2(DEPTH);
    localparam int BYTES = DATA_W / 8;
    localparam int OW    = $clog2(BYTES);
    localparam logic [QW:0] READY_MAX = (QW+1)'(DEPTH - DIS_PORTS);
    localparam logic [QW:0] DEPTH_PTR = (QW+1)'(DEPTH);

    logic [QW:0]         head, tail, count, head_next, tail_next, dis_n, keep_n;
    logic [DEPTH-1:0]    valid, addr_valid, miss, data_valid, wb_done;
    logic [DEPTH-1:0]    commit_clr, squash, cand;
    logic [ROB_W-1:0]    rob_q  [DEPTH];
    logic [PREG_W-1:0]   rd_q   [DEPTH];
    logic [PADDR_W-1:OW] line_q [DEPTH];
    logic [BYTES-1:0]    mask_q [DEPTH];
    logic [BYTES-1:0]    fwd_q  [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic                ready, do_dis;
    logic [QW-1:0]       wb_pos, vio_pos;
    logic [QW-1:0]       wb_idx [WB_PORTS];
    logic [WB_PORTS-1:0] wb_sel;
    logic                wb_taken;
    logic [QW:0]         st_off [ST_PIPES];
    logic                vio_hit, vio_any, vio_valid_q;
    logic [ROB_W-1:0]    vio_rob_d, vio_rob_q;

    // ROB indices carry a wrap bit, so ordering flips when the dirs differ
    function automatic logic younger(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
        return (a[ROB_W-1] ^ b[ROB_W-1]) ^ (a[ROB_W-2:0] > b[ROB_W-2:0]);
    endfunction

    assign count  = tail - head;
    assign ready  = count <= READY_MAX;
    assign do_dis = ready && !bus.redirect;
    assign cand   = valid & miss & data_valid & ~wb_done;

    always_comb begin
        dis_n = '0;
        for (int k = 0; k < DIS_PORTS; k++)
            dis_n = dis_n + (QW+1)'(bus.dis_valid[k]);
        head_next  = head + (QW+1)'(bus.commit_num);
        commit_clr = '0;
        for (int k = 0; k < DIS_PORTS; k++)
            if (k < int'(bus.commit_num))
                commit_clr[head[QW-1:0] + QW'(k)] = 1'b1;
        squash = '0;
        keep_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash[i] = bus.redirect && valid[i] && younger(rob_q[i], bus.redirect_rob);
            keep_n    = keep_n + (QW+1)'(valid[i] && !squash[i] && !commit_clr[i]);
        end
        // survivors of a squash are contiguous from head, so their count rebuilds tail
        if (bus.redirect)
            tail_next = head_next + keep_n;
        else if (do_dis)
            tail_next = tail + dis_n;
        else
            tail_next = tail;
    end

    always_comb begin
        wb_sel   = '0;
        wb_pos   = '0;
        wb_taken = 1'b0;
        for (int k = 0; k < WB_PORTS; k++)
            wb_idx[k] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_pos   = head[QW-1:0] + QW'(i);
            wb_taken = 1'b0;
            for (int k = 0; k < WB_PORTS; k++) begin
                if (cand[wb_pos] && !wb_taken && !wb_sel[k]) begin
                    wb_sel[k] = 1'b1;
                    wb_idx[k] = wb_pos;
                    wb_taken  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        // a store whose recorded tail is behind head sees every live load as younger
        for (int s = 0; s < ST_PIPES; s++) begin
            st_off[s] = bus.st_lq[s*(QW+1) +: QW+1] - head;
            if (st_off[s] > DEPTH_PTR)
                st_off[s] = '0;
        end
        vio_hit   = 1'b0;
        vio_any   = 1'b0;
        vio_rob_d = '0;
        vio_pos   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vio_pos = head[QW-1:0] + QW'(i);
            vio_hit = 1'b0;
            for (int s = 0; s < ST_PIPES; s++)
                if (bus.st_en[s] && valid[vio_pos] && addr_valid[vio_pos]
                    && (QW+1)'(i) >= st_off[s]
                    && line_q[vio_pos] == bus.st_paddr[s*PADDR_W+OW +: PADDR_W-OW]
                    && |(mask_q[vio_pos] & bus.st_mask[s*BYTES +: BYTES]))
                    vio_hit = 1'b1;
            if (vio_hit && !vio_any) begin
                vio_any   = 1'b1;
                vio_rob_d = rob_q[vio_pos];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            valid       <= '0;
            addr_valid  <= '0;
            miss        <= '0;
            data_valid  <= '0;
            wb_done     <= '0;
            vio_valid_q <= 1'b0;
            vio_rob_q   <= '0;
        end else begin
            head <= head_next;
            tail <= tail_next;
            if (do_dis)
                for (int k = 0; k < DIS_PORTS; k++)
                    if (bus.dis_valid[k]) begin
                        valid[tail[QW-1:0] + QW'(k)]      <= 1'b1;
                        addr_valid[tail[QW-1:0] + QW'(k)] <= 1'b0;
                        miss[tail[QW-1:0] + QW'(k)]       <= 1'b0;
                        data_valid[tail[QW-1:0] + QW'(k)] <= 1'b0;
                        wb_done[tail[QW-1:0] + QW'(k)]    <= 1'b0;
                        rob_q[tail[QW-1:0] + QW'(k)]      <= bus.dis_rob[k*ROB_W +: ROB_W];
                        rd_q[tail[QW-1:0] + QW'(k)]       <= bus.dis_rd[k*PREG_W +: PREG_W];
                    end
            // refill first so a same-cycle issue result to the entry overrides it
            for (int r = 0; r < RF_PORTS; r++)
                if (bus.rf_en[r] && valid[bus.rf_idx[r*QW +: QW]] && miss[bus.rf_idx[r*QW +: QW]]) begin
                    for (int b = 0; b < BYTES; b++)
                        if (!fwd_q[bus.rf_idx[r*QW +: QW]][b])
                            data_q[bus.rf_idx[r*QW +: QW]][b*8 +: 8] <= bus.rf_data[r*DATA_W + b*8 +: 8];
                    data_valid[bus.rf_idx[r*QW +: QW]] <= 1'b1;
                end
            for (int p = 0; p < LD_PIPES; p++)
                if (bus.ld_en[p]) begin
                    addr_valid[bus.ld_idx[p*QW +: QW]] <= 1'b1;
                    miss[bus.ld_idx[p*QW +: QW]]       <= bus.ld_miss[p];
                    data_valid[bus.ld_idx[p*QW +: QW]] <= !bus.ld_miss[p];
                    wb_done[bus.ld_idx[p*QW +: QW]]    <= !bus.ld_miss[p];
                    line_q[bus.ld_idx[p*QW +: QW]]     <= bus.ld_paddr[p*PADDR_W+OW +: PADDR_W-OW];
                    mask_q[bus.ld_idx[p*QW +: QW]]     <= bus.ld_mask[p*BYTES +: BYTES];
                    fwd_q[bus.ld_idx[p*QW +: QW]]      <= bus.ld_fwd_mask[p*BYTES +: BYTES];
                    data_q[bus.ld_idx[p*QW +: QW]]     <= bus.ld_data[p*DATA_W +: DATA_W];
                end
            for (int k = 0; k < WB_PORTS; k++)
                if (wb_sel[k] && bus.wb_ready[k])
                    wb_done[wb_idx[k]] <= 1'b1;
            for (int i = 0; i < DEPTH; i++)
                if (commit_clr[i] || squash[i])
                    valid[i] <= 1'b0;
            vio_valid_q <= vio_any;
            if (vio_any)
                vio_rob_q <= vio_rob_d;
        end
    end

    always_comb begin
        bus.wb_rob  = '0;
        bus.wb_rd   = '0;
        bus.wb_data = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            bus.wb_rob[k*ROB_W +: ROB_W]    = rob_q[wb_idx[k]];
            bus.wb_rd[k*PREG_W +: PREG_W]   = rd_q[wb_idx[k]];
            bus.wb_data[k*DATA_W +: DATA_W] = data_q[wb_idx[k]];
        end
    end

    assign bus.wb_valid  = wb_sel;
    assign bus.dis_ready = ready;
    assign bus.lq_tail   = tail;
    assign bus.count     = count;
    assign bus.vio_valid = vio_valid_q;
    assign bus.vio_rob   = vio_rob_q;
endmodule

// File: tb/tb_lq_multiport.sv
// Self-checking bench for lq_multiport: an allocation/commit vector table plus directed
// refill, writeback, redirect, violation and wrap sequences with scoreboard queues.
module tb_lq_multiport;
    localparam int DEPTH = 32, DIS_PORTS = 2, LD_PIPES = 2, ST_PIPES = 2, WB_PORTS = 2;
    localparam int RF_PORTS = 2, ROB_W = 7, PREG_W = 7, DATA_W = 64, PADDR_W = 32;
    localparam int QW = 5, BYTES = 8;

    typedef struct {
        logic [1:0] dis;
        logic [1:0] commit;
        logic [5:0] exp_count;
        logic       exp_ready;
        logic [5:0] exp_tail;
    } vec_t;

    typedef struct {
        logic [6:0]  rob;
        logic [6:0]  rd;
        logic [63:0] data;
    } wb_t;

    logic       clk = 1'b0;
    logic       rst;
    int         tests = 0;
    int         fails = 0;
    logic [6:0] next_rob;
    wb_t        wb_q[$];
    logic [6:0] vio_q[$];
    vec_t       vecs[17];

    lq_multiport_if #(.DEPTH(DEPTH), .DIS_PORTS(DIS_PORTS), .LD_PIPES(LD_PIPES), .ST_PIPES(ST_PIPES),
        .WB_PORTS(WB_PORTS), .RF_PORTS(RF_PORTS), .ROB_W(ROB_W), .PREG_W(PREG_W),
        .DATA_W(DATA_W), .PADDR_W(PADDR_W)) bus ();

    lq_multiport #(.DEPTH(DEPTH), .DIS_PORTS(DIS_PORTS), .LD_PIPES(LD_PIPES), .ST_PIPES(ST_PIPES),
        .WB_PORTS(WB_PORTS), .RF_PORTS(RF_PORTS), .ROB_W(ROB_W), .PREG_W(PREG_W),
        .DATA_W(DATA_W), .PADDR_W(PADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.dis_valid = '0;     bus.dis_rob = '0;      bus.dis_rd = '0;
        bus.ld_en = '0;         bus.ld_idx = '0;       bus.ld_miss = '0;
        bus.ld_paddr = '0;      bus.ld_mask = '0;      bus.ld_fwd_mask = '0;
        bus.ld_data = '0;       bus.rf_en = '0;        bus.rf_idx = '0;
        bus.rf_data = '0;       bus.wb_ready = '0;     bus.commit_num = '0;
        bus.redirect = 1'b0;    bus.redirect_rob = '0; bus.st_en = '0;
        bus.st_paddr = '0;      bus.st_mask = '0;      bus.st_lq = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        next_rob = '0;
        wb_q.delete();
        vio_q.delete();
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.dis_valid = v.dis;
        for (int k = 0; k < DIS_PORTS; k++) begin
            bus.dis_rob[k*ROB_W +: ROB_W]  = next_rob + 7'(k);
            bus.dis_rd[k*PREG_W +: PREG_W] = next_rob + 7'(k) + 7'd40;
        end
        next_rob = next_rob + 7'(v.dis[0]) + 7'(v.dis[1]);
        bus.commit_num = v.commit;
        step();
        clear_inputs();
    endtask

    task automatic check_output(input vec_t v, input int r);
        check($sformatf("row%0d_count", r), bus.count, v.exp_count);
        check($sformatf("row%0d_ready", r), bus.dis_ready, v.exp_ready);
        check($sformatf("row%0d_tail", r), bus.lq_tail, v.exp_tail);
    endtask

    task automatic dispatch_n(input int n);
        vec_t v;
        int   left;
        left = n;
        v = vec_t'{2'b00, 2'd0, 6'd0, 1'b0, 6'd0};
        while (left > 0) begin
            v.dis = (left >= 2) ? 2'b11 : 2'b01;
            apply_stimulus(v);
            left -= 2;
        end
    endtask

    task automatic set_ld(input int p, input logic [4:0] idx, input logic m, input logic [31:0] pa,
                          input logic [7:0] mask, input logic [7:0] fwd, input logic [63:0] data);
        bus.ld_en[p]                   = 1'b1;
        bus.ld_idx[p*QW +: QW]         = idx;
        bus.ld_miss[p]                 = m;
        bus.ld_paddr[p*PADDR_W +: PADDR_W] = pa;
        bus.ld_mask[p*BYTES +: BYTES]  = mask;
        bus.ld_fwd_mask[p*BYTES +: BYTES] = fwd;
        bus.ld_data[p*DATA_W +: DATA_W] = data;
    endtask

    task automatic set_rf(input int p, input logic [4:0] idx, input logic [63:0] data);
        bus.rf_en[p]                    = 1'b1;
        bus.rf_idx[p*QW +: QW]          = idx;
        bus.rf_data[p*DATA_W +: DATA_W] = data;
    endtask

    task automatic set_st(input int p, input logic [31:0] pa, input logic [7:0] mask, input logic [5:0] lq);
        bus.st_en[p]                       = 1'b1;
        bus.st_paddr[p*PADDR_W +: PADDR_W] = pa;
        bus.st_mask[p*BYTES +: BYTES]      = mask;
        bus.st_lq[p*(QW+1) +: QW+1]        = lq;
    endtask

    task automatic check_vio(input string name);
        logic [6:0] e;
        check({name, "_valid"}, bus.vio_valid, 64'(vio_q.size() != 0));
        if (vio_q.size() != 0) begin
            e = vio_q.pop_front();
            check({name, "_rob"}, bus.vio_rob, e);
        end
    endtask

    task automatic drain(input int max_cycles);
        int  cyc;
        wb_t e;
        cyc = 0;
        bus.wb_ready = '1;
        while ((wb_q.size() != 0 || bus.wb_valid != '0) && cyc < max_cycles) begin
            for (int k = 0; k < WB_PORTS; k++)
                if (bus.wb_valid[k]) begin
                    if (wb_q.size() == 0)
                        check("wb_unexpected_valid", bus.wb_valid[k], 0);
                    else begin
                        e = wb_q.pop_front();
                        check($sformatf("wb%0d_rob", k), bus.wb_rob[k*ROB_W +: ROB_W], e.rob);
                        check($sformatf("wb%0d_rd", k), bus.wb_rd[k*PREG_W +: PREG_W], e.rd);
                        check($sformatf("wb%0d_data", k), bus.wb_data[k*DATA_W +: DATA_W], e.data);
                    end
                end
            step();
            cyc++;
        end
        check("wb_drain_done", 64'(wb_q.size() == 0 && bus.wb_valid == '0), 1);
        bus.wb_ready = '0;
    endtask

    initial begin
        for (int r = 0; r < 16; r++)
            vecs[r] = vec_t'{2'b11, 2'd0, 6'(2*(r+1)), 1'((2*(r+1)) <= 30), 6'(2*(r+1))};
        vecs[16] = vec_t'{2'b00, 2'd2, 6'd30, 1'b1, 6'd32};

        // reset with a dispatch request present: reset must win
        clear_inputs();
        bus.dis_valid = 2'b11;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.dis_valid = '0;
        next_rob = '0;
        check("rst_count", bus.count, 0);
        check("rst_ready", bus.dis_ready, 1);
        check("rst_tail", bus.lq_tail, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_vio_valid", bus.vio_valid, 0);
        check("rst_vio_rob", bus.vio_rob, 0);

        for (int r = 0; r < 17; r++) begin
            apply_stimulus(vecs[r]);
            check_output(vecs[r], r);
        end

        // miss with forwarded low bytes, refill merge, hold under back-pressure
        do_reset();
        dispatch_n(10);
        set_ld(0, 5'd5, 1'b1, 32'h100, 8'hFF, 8'h0F, 64'h0000_0000_1122_3344);
        step();
        clear_inputs();
        check("miss_no_wb", bus.wb_valid, 0);
        set_rf(0, 5'd5, 64'hAABB_CCDD_EEFF_0011);
        wb_q.push_back(wb_t'{7'd5, 7'd45, 64'hAABB_CCDD_1122_3344});
        step();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            check("hold_valid", bus.wb_valid, 2'b01);
            check("hold_rob", bus.wb_rob[6:0], wb_q[0].rob);
            check("hold_data", bus.wb_data[63:0], wb_q[0].data);
            step();
        end
        drain(4);
        check("wb5_gone", bus.wb_valid, 0);

        // three refilled misses: oldest two first, then the third
        do_reset();
        dispatch_n(10);
        set_ld(0, 5'd9, 1'b1, 32'h200, 8'hFF, 8'h00, 64'h0);
        set_ld(1, 5'd3, 1'b1, 32'h300, 8'hFF, 8'h00, 64'h0);
        step();
        clear_inputs();
        set_ld(0, 5'd7, 1'b1, 32'h400, 8'hFF, 8'h00, 64'h0);
        step();
        clear_inputs();
        set_rf(0, 5'd3, 64'h0303_0303_0303_0303);
        set_rf(1, 5'd7, 64'h0707_0707_0707_0707);
        wb_q.push_back(wb_t'{7'd3, 7'd43, 64'h0303_0303_0303_0303});
        wb_q.push_back(wb_t'{7'd7, 7'd47, 64'h0707_0707_0707_0707});
        step();
        clear_inputs();
        set_rf(0, 5'd9, 64'h0909_0909_0909_0909);
        wb_q.push_back(wb_t'{7'd9, 7'd49, 64'h0909_0909_0909_0909});
        step();
        clear_inputs();
        check("order_valid", bus.wb_valid, 2'b11);
        check("order_port0", bus.wb_rob[6:0], 3);
        check("order_port1", bus.wb_rob[13:7], 7);
        drain(6);

        // redirect squashes rob 15..19; dispatch in that cycle is dropped
        do_reset();
        next_rob = 7'd10;
        dispatch_n(10);
        check("pre_redir_count", bus.count, 10);
        bus.redirect = 1'b1;
        bus.redirect_rob = 7'd14;
        bus.dis_valid = 2'b11;
        step();
        clear_inputs();
        check("redir_count", bus.count, 5);
        check("redir_tail", bus.lq_tail, 5);
        next_rob = 7'd20;
        dispatch_n(2);
        check("post_redir_tail", bus.lq_tail, 7);
        check("post_redir_count", bus.count, 7);
        bus.redirect = 1'b1;
        bus.redirect_rob = 7'd12;
        bus.commit_num = 2'd2;
        step();
        clear_inputs();
        check("redir_commit_count", bus.count, 1);
        check("redir_commit_tail", bus.lq_tail, 3);

        // store-to-load violations
        do_reset();
        dispatch_n(8);
        set_ld(0, 5'd4, 1'b0, 32'h1000, 8'h03, 8'h00, 64'h0);
        set_ld(1, 5'd6, 1'b0, 32'h1000, 8'h03, 8'h00, 64'h0);
        step();
        clear_inputs();
        set_st(0, 32'h1000, 8'h01, 6'd3);
        vio_q.push_back(7'd4);
        step();
        clear_inputs();
        check_vio("vio_basic");
        step();
        check_vio("vio_clear");
        set_st(0, 32'h1008, 8'h01, 6'd3);
        step();
        clear_inputs();
        check_vio("vio_other_line");
        set_st(0, 32'h1000, 8'h04, 6'd3);
        step();
        clear_inputs();
        check_vio("vio_no_overlap");
        set_st(0, 32'h1000, 8'h02, 6'd5);
        set_st(1, 32'h1000, 8'h01, 6'd3);
        vio_q.push_back(7'd4);
        step();
        clear_inputs();
        check_vio("vio_two_ports");
        set_st(1, 32'h1000, 8'h01, 6'd5);
        vio_q.push_back(7'd6);
        step();
        clear_inputs();
        check_vio("vio_port1");

        // wrap: head=30, tail=34 (dir set)
        do_reset();
        dispatch_n(32);
        for (int c = 0; c < 15; c++) begin
            bus.commit_num = 2'd2;
            step();
        end
        clear_inputs();
        dispatch_n(2);
        check("wrap_count", bus.count, 4);
        check("wrap_tail", bus.lq_tail, 34);
        check("wrap_ready", bus.dis_ready, 1);
        set_ld(0, 5'd30, 1'b0, 32'h2000, 8'h01, 8'h00, 64'h0);
        set_ld(1, 5'd31, 1'b0, 32'h2000, 8'h01, 8'h00, 64'h0);
        step();
        clear_inputs();
        set_ld(0, 5'd0, 1'b0, 32'h2000, 8'h01, 8'h00, 64'h0);
        set_ld(1, 5'd1, 1'b0, 32'h2000, 8'h01, 8'h00, 64'h0);
        step();
        clear_inputs();
        set_st(0, 32'h2000, 8'h01, 6'd31);
        vio_q.push_back(7'd31);
        step();
        clear_inputs();
        check_vio("wrap_st31");
        set_st(1, 32'h2000, 8'h01, 6'd32);
        vio_q.push_back(7'd32);
        step();
        clear_inputs();
        check_vio("wrap_st32");
        set_st(0, 32'h2000, 8'h01, 6'd34);
        step();
        clear_inputs();
        check_vio("wrap_at_tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
